// File: rtl/mult_share_sched_if.sv
// Bundles the requester handshakes, shared-multiplier hookup and result/status outputs of mult_share_sched.
// Handshake: a requester raises reqN with stable aN/bN and holds them until the single-cycle gntN pulse;
// the operands were taken on the edge that raised gntN, and doneN pulses for one cycle when d_out holds that job's result.
interface mult_share_sched_if;
  logic        req0;
  logic [7:0]  a0;
  logic [7:0]  b0;
  logic        req1;
  logic [7:0]  a1;
  logic [7:0]  b1;
  logic        gnt0;
  logic        gnt1;
  logic [3:0]  mul_a;
  logic [3:0]  mul_b;
  logic [7:0]  mul_p;
  logic [15:0] d_out;
  logic        done0;
  logic        done1;
  logic        busy;
  logic [2:0]  state;

  modport master (
    output req0, a0, b0, req1, a1, b1, mul_p,
    input  gnt0, gnt1, mul_a, mul_b, d_out, done0, done1, busy, state
  );

  modport slave (
    input  req0, a0, b0, req1, a1, b1, mul_p,
    output gnt0, gnt1, mul_a, mul_b, d_out, done0, done1, busy, state
  );
endinterface

// File: rtl/mult_share_sched.sv
// Round-robin scheduler sharing one external 4x4 multiplier between two 8x8 requesters.
// Optional macro MULT_ZERO_SKIP_EN: a zero operand at capture jumps straight to DONE with a 0 result.
module mult_share_sched #(
  parameter bit          PRIO_INIT = 1'b0,
  parameter int unsigned IDLE_GAP  = 0
) (
  input  logic              clk,
  input  logic              rst,
  mult_share_sched_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P0   = 3'd1,
    S_P1   = 3'd2,
    S_P2   = 3'd3,
    S_P3   = 3'd4,
    S_DONE = 3'd5,
    S_GAP  = 3'd6
  } state_t;

  localparam logic [2:0] GAP_LAST = (IDLE_GAP == 0) ? 3'd0 : 3'(IDLE_GAP - 1);

  state_t      state_q;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic        owner;
  logic        prio;
  logic [15:0] acc;
  logic [15:0] d_out_q;
  logic        gnt0_q;
  logic        gnt1_q;
  logic        done0_q;
  logic        done1_q;
  logic [2:0]  gap_cnt;

  logic        any_req;
  logic        win;
  logic [7:0]  win_a;
  logic [7:0]  win_b;
  logic        skip;
  logic [15:0] sum_mid;
  logic [15:0] sum_top;

  // prio names the requester that wins the next tie; a lone requester always wins.
  always_comb begin
    any_req = bus.req0 | bus.req1;
    win     = 1'b0;
    if (bus.req0 && bus.req1) win = prio;
    else if (bus.req1)        win = 1'b1;
    win_a   = win ? bus.a1 : bus.a0;
    win_b   = win ? bus.b1 : bus.b0;
  end

`ifdef MULT_ZERO_SKIP_EN
  assign skip = (win_a == 8'd0) || (win_b == 8'd0);
`else
  assign skip = 1'b0;
`endif

  assign sum_mid = acc + {4'd0, bus.mul_p, 4'd0};
  assign sum_top = acc + {bus.mul_p, 8'd0};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_a    <= 8'd0;
      op_b    <= 8'd0;
      owner   <= 1'b0;
      prio    <= PRIO_INIT;
      acc     <= 16'd0;
      d_out_q <= 16'd0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      gap_cnt <= 3'd0;
    end else begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            op_a   <= win_a;
            op_b   <= win_b;
            owner  <= win;
            prio   <= ~win;
            gnt0_q <= ~win;
            gnt1_q <= win;
            if (skip) begin
              acc     <= 16'd0;
              d_out_q <= 16'd0;
              done0_q <= ~win;
              done1_q <= win;
              state_q <= S_DONE;
            end else begin
              state_q <= S_P0;
            end
          end
        end
        S_P0: begin
          acc     <= {8'd0, bus.mul_p};
          state_q <= S_P1;
        end
        S_P1: begin
          acc     <= sum_mid;
          state_q <= S_P2;
        end
        S_P2: begin
          acc     <= sum_mid;
          state_q <= S_P3;
        end
        // The final partial product lands directly in d_out as DONE is entered.
        S_P3: begin
          acc     <= sum_top;
          d_out_q <= sum_top;
          done0_q <= ~owner;
          done1_q <= owner;
          state_q <= S_DONE;
        end
        S_DONE: begin
          gap_cnt <= 3'd0;
          state_q <= (IDLE_GAP > 0) ? S_GAP : S_IDLE;
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) state_q <= S_IDLE;
          else                     gap_cnt <= gap_cnt + 3'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.mul_a = 4'd0;
    bus.mul_b = 4'd0;
    case (state_q)
      S_P0: begin bus.mul_a = op_a[3:0]; bus.mul_b = op_b[3:0]; end
      S_P1: begin bus.mul_a = op_a[7:4]; bus.mul_b = op_b[3:0]; end
      S_P2: begin bus.mul_a = op_a[3:0]; bus.mul_b = op_b[7:4]; end
      S_P3: begin bus.mul_a = op_a[7:4]; bus.mul_b = op_b[7:4]; end
      default: ;
    endcase
  end

  assign bus.gnt0  = gnt0_q;
  assign bus.gnt1  = gnt1_q;
  assign bus.done0 = done0_q;
  assign bus.done1 = done1_q;
  assign bus.d_out = d_out_q;
  assign bus.busy  = (state_q != S_IDLE);
  assign bus.state = state_q;

endmodule

// File: tb/tb_mult_share_sched.sv
// Bench for mult_share_sched: directed scenarios plus random single jobs against a product/arbitration model.
module tb_mult_share_sched;
  localparam bit PRIO_INIT = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   exp_prio;

  mult_share_sched_if bus();

  mult_share_sched #(.PRIO_INIT(PRIO_INIT), .IDLE_GAP(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Shared combinational 4x4 multiplier.
  assign bus.mul_p = bus.mul_a * bus.mul_b;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [7:0] a, input logic [7:0] b);
`ifdef MULT_ZERO_SKIP_EN
    return (a == 8'd0 || b == 8'd0) ? 1 : 5;
`else
    return 5;
`endif
  endfunction

  function automatic logic [15:0] prod(input logic [7:0] a, input logic [7:0] b);
    return 16'(a) * 16'(b);
  endfunction

  task automatic set_req(input bit id, input logic v, input logic [7:0] a, input logic [7:0] b);
    if (id) begin bus.req1 = v; bus.a1 = a; bus.b1 = b; end
    else    begin bus.req0 = v; bus.a0 = a; bus.b0 = b; end
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (bus.state !== 3'd0 && k < 20) begin @(negedge clk); k++; end
    if (k >= 20) check("idle_timeout", 32'(bus.state), 32'd0);
  endtask

  task automatic expect_grant(input bit id, output int waited);
    waited = 1;
    @(posedge clk); #1;
    while (!(bus.gnt0 || bus.gnt1) && waited < 20) begin @(posedge clk); #1; waited++; end
    check("gnt0", 32'(bus.gnt0), 32'(!id));
    check("gnt1", 32'(bus.gnt1), 32'(id));
    exp_prio = !id;
  endtask

  task automatic wait_done(input bit id, input logic [15:0] exp_d, input int lat_exp);
    int lat = 1;
    while (!(bus.done0 || bus.done1) && lat < 12) begin @(posedge clk); #1; lat++; end
    check("done_latency", 32'(lat), 32'(lat_exp));
    check("done0", 32'(bus.done0), 32'(!id));
    check("done1", 32'(bus.done1), 32'(id));
    check("d_out", 32'(bus.d_out), 32'(exp_d));
    check("state_done", 32'(bus.state), 32'd5);
    @(posedge clk); #1;
    check("d_out_hold", 32'(bus.d_out), 32'(exp_d));
    check("done_clear", 32'({bus.done0, bus.done1}), 32'd0);
  endtask

  task automatic run_single(input bit id, input logic [7:0] a, input logic [7:0] b);
    int w;
    wait_idle();
    set_req(id, 1'b1, a, b);
    expect_grant(id, w);
    check("grant_wait", 32'(w), 32'd1);
    // Drop the request and disturb the operands; the captured job must be unaffected.
    set_req(id, 1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    wait_done(id, prod(a, b), exp_lat(a, b));
  endtask

  initial begin
    int w;
    bit id;
    logic [7:0] ra, rb, pa0, pb0, pa1, pb1;
    bus.req0 = 1'b0; bus.a0 = 8'd0; bus.b0 = 8'd0;
    bus.req1 = 1'b0; bus.a1 = 8'd0; bus.b1 = 8'd0;
    exp_prio = PRIO_INIT;

    // Reset state
    #12;
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_gnt", 32'({bus.gnt0, bus.gnt1}), 32'd0);
    check("rst_done", 32'({bus.done0, bus.done1}), 32'd0);
    check("rst_d_out", 32'(bus.d_out), 32'd0);
    check("rst_mul", 32'({bus.mul_a, bus.mul_b}), 32'd0);
    @(negedge clk); rst = 1'b1;

    // Simultaneous requests on the first arbitration
    wait_idle();
    set_req(0, 1'b1, 8'h03, 8'h05);
    set_req(1, 1'b1, 8'h12, 8'h34);
    expect_grant(PRIO_INIT, w);
    check("tie_busy", 32'(bus.busy), 32'd1);
    set_req(PRIO_INIT, 1'b0, 8'h00, 8'h00);
    wait_done(PRIO_INIT, PRIO_INIT ? 16'h03A8 : 16'h000F, 5);
    expect_grant(!PRIO_INIT, w);
    set_req(!PRIO_INIT, 1'b0, 8'h00, 8'h00);
    wait_done(!PRIO_INIT, PRIO_INIT ? 16'h000F : 16'h03A8, 5);

    // Largest operands
    run_single(0, 8'hFF, 8'hFF);

    // Zero operand
    run_single(0, 8'h00, 8'h77);

    // Both requests held: grants must alternate
    wait_idle();
    pa0 = 8'($urandom_range(1, 255)); pb0 = 8'($urandom_range(1, 255));
    pa1 = 8'($urandom_range(1, 255)); pb1 = 8'($urandom_range(1, 255));
    set_req(0, 1'b1, pa0, pb0);
    set_req(1, 1'b1, pa1, pb1);
    for (int j = 0; j < 6; j++) begin
      id = exp_prio;
      expect_grant(id, w);
      if (j == 5) begin
        set_req(0, 1'b0, pa0, pb0);
        set_req(1, 1'b0, pa1, pb1);
      end
      wait_done(id, id ? prod(pa1, pb1) : prod(pa0, pb0), 5);
    end

    // Random single jobs, occasionally with a zero operand
    for (int j = 0; j < 16; j++) begin
      id = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      run_single(id, ra, rb);
    end

    // Reset while the job sits in P2
    wait_idle();
    set_req(0, 1'b1, 8'h55, 8'h66);
    expect_grant(0, w);
    set_req(0, 1'b0, 8'h00, 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("p2_state", 32'(bus.state), 32'd3);
    check("p2_mul_a", 32'(bus.mul_a), 32'h5);
    check("p2_mul_b", 32'(bus.mul_b), 32'h6);
    #2 rst = 1'b0;
    #1;
    check("midrst_state", 32'(bus.state), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_d_out", 32'(bus.d_out), 32'd0);
    check("midrst_mul", 32'({bus.mul_a, bus.mul_b}), 32'd0);
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      check("midrst_no_done", 32'({bus.done0, bus.done1}), 32'd0);
    end
    @(negedge clk); rst = 1'b1;
    exp_prio = PRIO_INIT;
    run_single(0, 8'h80, 8'h02);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
